// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, FSM encoding and coefficient address map for the IIR datapath.
package iir_pkg;
   localparam int INT = 12;
   localparam int FRAC = 16;
   localparam int SW = INT + FRAC + 1;
   localparam int AW = 2 * (INT + FRAC) + 1;
   localparam int PW = 2 * SW;
   localparam int ACW = 2 * SW + 2;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MAC_FF = 3'd1;
   localparam logic [2:0] S_MAC_FB = 3'd2;
   localparam logic [2:0] S_OUT    = 3'd3;
   localparam logic [2:0] S_WAIT_Y = 3'd4;
   localparam logic [3:0] ADDR_B0  = 4'd0;
   function automatic logic [3:0] addr_a1(input int order);
      return 4'(order + 1);
   endfunction
endpackage

// File: rtl/iir_mac_seq_if.sv
// iir_mac_seq_if: sample input, coefficient/feedback write and sum output bundle.
interface iir_mac_seq_if;
   import iir_pkg::*;
   logic          s_valid;
   logic          s_ready;
   logic [SW-1:0] s_data;
   logic          coef_we;
   logic [3:0]    coef_addr;
   logic [SW-1:0] coef_data;
   logic          y_wr_en;
   logic [SW-1:0] y_wr_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW-1:0] m_ff;
   logic [AW-1:0] m_fb;
   logic          err;
   modport slave (input s_valid, s_data, coef_we, coef_addr, coef_data, y_wr_en, y_wr_data, m_ready,
                  output s_ready, m_valid, m_ff, m_fb, err);
   modport master (output s_valid, s_data, coef_we, coef_addr, coef_data, y_wr_en, y_wr_data, m_ready,
                   input s_ready, m_valid, m_ff, m_fb, err);
endinterface

// File: rtl/iir_sat.sv
// iir_sat: clamps a guarded accumulator to the signed AW-bit range.
module iir_sat
   import iir_pkg::*;
(
   input  logic [ACW-1:0] i_d,
   output logic [AW-1:0]  o_q
);
   logic [ACW-AW:0] w_hi;
   assign w_hi = i_d[ACW-1:AW-1];
   // guard bits all equal to the AW sign bit means the value already fits
   assign o_q = (&w_hi || ~|w_hi) ? i_d[AW-1:0] : {i_d[ACW-1], {(AW-1){~i_d[ACW-1]}}};
endmodule

// File: rtl/iir_mac_seq.sv
// iir_mac_seq: one-multiplier sequencer producing feed-forward and feedback IIR sums.
module iir_mac_seq
   import iir_pkg::*;
#(
   parameter int ORDER = 2
)(
   input logic          aclk,
   input logic          aresetn,
   iir_mac_seq_if.slave bus
);
   logic [2:0]           r_state;
   logic [3:0]           r_k;
   logic signed [SW-1:0] r_x [0:ORDER];
   logic signed [SW-1:0] r_y [0:ORDER];
   logic signed [SW-1:0] r_b [0:ORDER];
   logic signed [SW-1:0] r_a [0:ORDER];
   logic [ACW-1:0]       r_acc_ff, r_acc_fb;
   logic [AW-1:0]        r_m_ff, r_m_fb;
   logic                 r_err;
   logic signed [SW-1:0] w_ma, w_mb;
   logic signed [PW-1:0] w_prod;
   logic [ACW-1:0]       w_prod_x;
   logic [AW-1:0]        w_sat_ff, w_sat_fb;
   always_comb begin
      w_ma = '0;
      w_mb = '0;
      for (int i = 0; i <= ORDER; i++)
         if (r_k == 4'(i)) begin
            w_ma = (r_state == S_MAC_FF) ? r_b[i] : r_a[i];
            w_mb = (r_state == S_MAC_FF) ? r_x[i] : r_y[i];
         end
   end
   assign w_prod = w_ma * w_mb;
   assign w_prod_x = {{2{w_prod[PW-1]}}, w_prod};
   iir_sat u_sat_ff (.i_d(r_acc_ff), .o_q(w_sat_ff));
   iir_sat u_sat_fb (.i_d(r_acc_fb), .o_q(w_sat_fb));
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_acc_ff <= '0;
         r_acc_fb <= '0;
         r_m_ff   <= '0;
         r_m_fb   <= '0;
         r_err    <= 1'b0;
         for (int i = 0; i <= ORDER; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
            r_b[i] <= '0;
            r_a[i] <= '0;
         end
      end else begin
         r_err <= r_err | (bus.coef_we && r_state != S_IDLE) | (bus.y_wr_en && r_state != S_WAIT_Y);
         case (r_state)
            S_IDLE: begin
               if (bus.coef_we)
                  for (int i = 0; i <= ORDER; i++) begin
                     if (bus.coef_addr == ADDR_B0 + 4'(i)) r_b[i] <= bus.coef_data;
                     if (i > 0 && bus.coef_addr == addr_a1(ORDER) + 4'(i - 1)) r_a[i] <= bus.coef_data;
                  end
               if (bus.s_valid) begin
                  r_x[0] <= bus.s_data;
                  for (int i = 1; i <= ORDER; i++) r_x[i] <= r_x[i-1];
                  r_acc_ff <= '0;
                  r_acc_fb <= '0;
                  r_k      <= '0;
                  r_state  <= S_MAC_FF;
               end
            end
            S_MAC_FF: begin
               r_acc_ff <= r_acc_ff + w_prod_x;
               r_k      <= (r_k == 4'(ORDER)) ? 4'd1 : r_k + 4'd1;
               if (r_k == 4'(ORDER)) r_state <= S_MAC_FB;
            end
            S_MAC_FB: begin
               // extra cycle after the last term registers the saturated sums
               if (r_k == 4'(ORDER + 1)) begin
                  r_m_ff  <= w_sat_ff;
                  r_m_fb  <= w_sat_fb;
                  r_state <= S_OUT;
               end else begin
                  r_acc_fb <= r_acc_fb + w_prod_x;
                  r_k      <= r_k + 4'd1;
               end
            end
            S_OUT: if (bus.m_ready) r_state <= S_WAIT_Y;
            S_WAIT_Y: begin
               if (bus.y_wr_en) begin
                  r_y[1] <= bus.y_wr_data;
                  for (int i = 2; i <= ORDER; i++) r_y[i] <= r_y[i-1];
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign bus.s_ready = (r_state == S_IDLE);
   assign bus.m_valid = (r_state == S_OUT);
   assign bus.m_ff    = r_m_ff;
   assign bus.m_fb    = r_m_fb;
   assign bus.err     = r_err;
endmodule

// File: tb/tb_iir_mac_seq.sv
// tb_iir_mac_seq: scoreboard bench; a reference model queues expected sums at each accept.
module tb_iir_mac_seq;
   import iir_pkg::*;
   typedef struct packed {logic [AW-1:0] ff; logic [AW-1:0] fb;} sums_t;
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   iir_mac_seq_if bus();
   iir_mac_seq #(.ORDER(2)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
   always #5 aclk = ~aclk;
   int n_chk = 0;
   int n_err = 0;
   sums_t q[$];
   longint mb[0:2], ma[0:2], mx[0:2], my[0:2];
   bit exp_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input logic [SW-1:0] d);
      return longint'($signed(d));
   endfunction

   function automatic logic [AW-1:0] sat(input longint v);
      longint lim = longint'(1) <<< (AW - 1);
      longint r = v;
      if (r > lim - 1) r = lim - 1;
      else if (r < -lim) r = -lim;
      return r[AW-1:0];
   endfunction

   task automatic do_reset();
      #2 aresetn = 1'b0;
      #1;
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_ff", bus.m_ff, 0);
      check("rst_m_fb", bus.m_fb, 0);
      check("rst_err", bus.err, 0);
      for (int i = 0; i < 3; i++) begin
         mb[i] = 0; ma[i] = 0; mx[i] = 0; my[i] = 0;
      end
      q.delete();
      exp_err = 1'b0;
      @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask

   task automatic wr_coef(input logic [3:0] a, input logic [SW-1:0] d);
      int ai = int'(a);
      bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
      @(posedge aclk); #1;
      bus.coef_we = 1'b0;
      if (ai <= 2) mb[ai] = sx(d);
      else if (ai <= 4) ma[ai-2] = sx(d);
   endtask

   task automatic start(input logic [SW-1:0] x);
      longint ff = 0;
      longint fb = 0;
      check("s_ready_idle", bus.s_ready, 1);
      bus.s_valid = 1'b1; bus.s_data = x;
      @(posedge aclk); #1;
      bus.s_valid = 1'b0;
      mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = sx(x);
      for (int i = 0; i < 3; i++) ff += mb[i] * mx[i];
      for (int i = 1; i < 3; i++) fb += ma[i] * my[i];
      q.push_back('{ff: sat(ff), fb: sat(fb)});
   endtask

   task automatic run(input logic [SW-1:0] x, input logic [SW-1:0] yv, input int hold,
                      input bit pulse_y, input bit bad_coef);
      int e = 0;
      sums_t s;
      start(x);
      while (!bus.m_valid && e < 20) begin
         if (bad_coef && e == 0) begin
            bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 29'h10000;
            exp_err = 1'b1;
         end
         @(posedge aclk); #1;
         bus.coef_we = 1'b0;
         e++;
      end
      check("latency", e, 6);
      s = (q.size() > 0) ? q[0] : '0;
      check("ff_first", bus.m_ff, s.ff);
      check("fb_first", bus.m_fb, s.fb);
      for (int i = 0; i < hold; i++) begin
         if (pulse_y && i == 4) begin
            bus.y_wr_en = 1'b1; bus.y_wr_data = 29'h10000;
            exp_err = 1'b1;
         end
         @(posedge aclk); #1;
         bus.y_wr_en = 1'b0;
      end
      if (hold > 0) begin
         check("s_ready_busy", bus.s_ready, 0);
         check("m_valid_held", bus.m_valid, 1);
      end
      bus.m_ready = 1'b1;
      s = (q.size() > 0) ? q.pop_front() : '0;
      check("ff_hs", bus.m_ff, s.ff);
      check("fb_hs", bus.m_fb, s.fb);
      @(posedge aclk); #1;
      bus.m_ready = 1'b0;
      check("m_valid_drop", bus.m_valid, 0);
      bus.y_wr_en = 1'b1; bus.y_wr_data = yv;
      @(posedge aclk); #1;
      bus.y_wr_en = 1'b0;
      my[2] = my[1]; my[1] = sx(yv);
      check("err", bus.err, exp_err);
   endtask

   initial begin
      bus.s_valid = 0; bus.s_data = '0; bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0;
      bus.y_wr_en = 0; bus.y_wr_data = '0; bus.m_ready = 0;
      do_reset();
      // impulse through the feed-forward taps
      wr_coef(4'd0, 29'h10000); wr_coef(4'd1, 29'h08000); wr_coef(4'd2, 29'h04000);
      run(29'h10000, '0, 0, 0, 0);
      run('0, '0, 0, 0, 0);
      run('0, '0, 0, 0, 0);
      check("impulse_sb_empty", q.size(), 0);
      // reset while the feedback terms are being accumulated
      start(29'h10000);
      repeat (4) begin @(posedge aclk); #1; end
      check("mid_busy", bus.s_ready, 0);
      do_reset();
      wr_coef(4'd0, 29'h10000); wr_coef(4'd1, 29'h08000); wr_coef(4'd2, 29'h04000);
      run(29'h10000, '0, 0, 0, 0);
      run('0, '0, 0, 0, 0);
      // feedback path
      do_reset();
      wr_coef(4'd0, 29'h10000); wr_coef(4'd3, 29'h08000);
      run(29'h10000, 29'h10000, 0, 0, 0);
      run('0, '0, 0, 0, 0);
      // backpressure with a stray y write
      run(29'h10000, '0, 10, 1, 0);
      // saturation and a dropped coefficient write
      do_reset();
      wr_coef(4'd0, 29'h10000000); wr_coef(4'd1, 29'h10000000); wr_coef(4'd2, 29'h10000000);
      run(29'h10000000, '0, 0, 0, 1);
      run(29'h10000000, '0, 0, 0, 0);
      run(29'h10000000, '0, 0, 0, 0);
      check("sat_max", bus.m_ff, {1'b0, {(AW-1){1'b1}}});
      run('0, '0, 0, 0, 0);
      run('0, '0, 0, 0, 0);
      run('0, '0, 0, 0, 0);
      run(29'h10000, '0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
